// File: rtl/c432_bist_ctrl_if.sv
// Stimulus/response and status bundle between the c432 BIST sequencer and its environment.
// The master side is the sequencer; the slave side is the test controller plus the c432 instance.
interface c432_bist_ctrl_if;
  logic        start;
  logic [35:0] dut_in;
  logic [6:0]  dut_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;
  logic [15:0] pattern_idx;

  modport master (
    input  start,
    input  dut_out,
    output dut_in,
    output busy,
    output done,
    output pass,
    output signature,
    output pattern_idx
  );

  modport slave (
    output start,
    output dut_out,
    input  dut_in,
    input  busy,
    input  done,
    input  pass,
    input  signature,
    input  pattern_idx
  );
endinterface

// File: rtl/c432_bist_ctrl.sv
// LFSR-driven self-test sequencer for c432: applies PATTERN_COUNT patterns, each held
// HOLD_CYCLES cycles, compacts the responses into a 16-bit MISR and compares to GOLDEN_SIG.
module c432_bist_ctrl #(
  parameter int unsigned PATTERN_COUNT = 1024,
  parameter int unsigned HOLD_CYCLES   = 1,
  parameter logic [35:0] LFSR_SEED     = 36'h000000001,
  parameter logic [15:0] GOLDEN_SIG    = 16'h0000
) (
  input logic            clk,
  input logic            rst,
  c432_bist_ctrl_if.master bist
);

  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  localparam logic [35:0] SEED      = (LFSR_SEED == 36'h0) ? 36'h1 : LFSR_SEED;
  localparam logic [15:0] LAST_IDX  = 16'(PATTERN_COUNT - 1);
  localparam logic [3:0]  LAST_HOLD = 4'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [35:0] lfsr_q, lfsr_d;
  logic [15:0] misr_q, misr_d;
  logic [15:0] idx_q, idx_d;
  logic [3:0]  hold_q, hold_d;
  logic        pass_q, pass_d;
  logic [15:0] misr_next;

  function automatic logic [35:0] lfsr_step(input logic [35:0] q);
    return {q[34:0], q[35] ^ q[24]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [6:0] d);
    return {m[14:0], m[15] ^ m[14] ^ m[12] ^ m[3]} ^ {9'b0, d};
  endfunction

  assign misr_next = misr_step(misr_q, bist.dut_out);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bist.start) begin
          state_d = RUN;
          lfsr_d  = SEED;
          misr_d  = 16'h0;
          idx_d   = 16'h0;
          hold_d  = 4'h0;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        if (hold_q == LAST_HOLD) begin
          // End of the hold window: absorb the settled response and step to the next pattern.
          misr_d = misr_next;
          hold_d = 4'h0;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            pass_d  = (misr_next == GOLDEN_SIG);
          end else begin
            lfsr_d = lfsr_step(lfsr_q);
            idx_d  = idx_q + 16'd1;
          end
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= 36'h0;
      misr_q  <= 16'h0;
      idx_q   <= 16'h0;
      hold_q  <= 4'h0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      pass_q  <= pass_d;
    end
  end

  assign bist.dut_in      = lfsr_q;
  assign bist.busy        = (state_q == RUN);
  assign bist.done        = (state_q == DONE);
  assign bist.pass        = pass_q;
  assign bist.signature   = misr_q;
  assign bist.pattern_idx = idx_q;

endmodule
